morse_decoder: RTL and testbench
================================

# morse_decoder

Receive-side counterpart of the lab Morse transmitter. Samples a serial dot/dash line, measures mark and space lengths in clock cycles, and assembles dots and dashes into a symbol buffer. After a letter gap it decodes the buffer to a 3-bit letter code (A–H), emitted with a one-cycle valid strobe. Invalid or over-long sequences produce a one-cycle error strobe instead.

## Interface
- CLOCK_FREQUENCY, default 500: clock cycles per second. UNIT = CLOCK_FREQUENCY/2 cycles is one Morse time unit. Must be even and ≥ 8.
- ClockIn  input  1  system clock; all state updates on the rising edge.
- ResetN  input  1  reset, asynchronous, active-low; clears all state.
- DotDashIn  input  1  serial Morse line, high = mark; asynchronous to ClockIn.
- Letter  output  3  decoded letter code, 000=A … 111=H; holds its value until the next LetterValid.
- LetterValid  output  1  one-cycle pulse; Letter is valid in that cycle.
- Error  output  1  one-cycle pulse; the sequence just ended was undecodable.
- Busy  output  1  high whenever state ≠ IDLE.

## Operation
- Input path:
  - DotDashIn passes through a 2-flop synchronizer; its output is S. All decisions use S.
- States:
  - IDLE: wait for S=1, then go to MARK with the mark counter = 1.
  - MARK: increment the mark counter each cycle S=1. The counter saturates at 5·UNIT; reaching 5·UNIT sets the error flag. On S=0, classify the mark and go to SPACE with the space counter = 1.
  - SPACE: increment the space counter each cycle S=0. On S=1, go to MARK with the mark counter = 1. When the space counter reaches 3·UNIT, go to EMIT.
  - EMIT: one cycle. Drive LetterValid or Error, clear the buffer, count and error flag, then go to IDLE.
- Mark classification when the mark ends:
  - length < UNIT/2: glitch. Discard it; no symbol is appended, and the space counter continues from the previous space value (not reset to 1).
  - length < 2·UNIT: dot, appended as 0.
  - length ≥ 2·UNIT: dash, appended as 1.
- Symbol buffer:
  - 4 bits shifted left, holding the symbols of the current letter; a 3-bit count (0–4) tracks how many are stored.
  - A 5th symbol sets the error flag; the buffer is not modified.
- Decode table (count: bits, first symbol is the MSB):
  - A 2:01, B 4:1000, C 4:1010, D 3:100, E 1:0, F 4:0010, G 3:110, H 4:0000.
  - Any other count/bits combination sets the error flag.
- Output selection in EMIT:
  - error flag set: Error=1, Letter unchanged.
  - count = 0 (only glitches received): neither strobe fires.
  - otherwise: LetterValid=1 and Letter is updated.
- Reset values: Letter=000, LetterValid=0, Error=0, Busy=0, state IDLE, buffer, count, flag and counters = 0.
- Reset asserted mid-letter: the partial letter is discarded silently; no strobe fires after release.
- Counters are 32 bits wide and saturate; they never wrap.

## Timing
- Synchronizer latency is 2 cycles. S reflects a DotDashIn level sampled at edge k after edge k+2.
- Let k be the first edge that samples DotDashIn low after the final mark. State is EMIT and LetterValid/Error are high in the cycle after edge k+2+3·UNIT; Busy falls one cycle later.
- LetterValid and Error are never high together and never high for more than one cycle.
- A space of 3·UNIT−1 cycles followed by a mark continues the same letter. A space of exactly 3·UNIT cycles ends the letter.
- A new mark arriving during EMIT is not lost. Because of the synchronizer, it is seen in IDLE on the following cycle.

## Test plan
- CLOCK_FREQUENCY=8 (UNIT=4) for all scenarios. Drive DotDashIn synchronously with ClockIn.
- Dot (4 high), 4 low, dash (12 high), 12 low -> one LetterValid with Letter=000 (A), 2+12 cycles after the dash ends; Error stays 0; Busy returns to 0.
- Dash, dot, dash, dot (4-cycle gaps between symbols), then 12 low -> Letter=010 (C). Repeat for all eight letters -> codes 000…111 in order.
- Dash, dash, dash (O, not in table), then 12 low -> Error pulses once and LetterValid stays 0. Five dots -> Error pulses once.
- Mark of 20+ cycles -> Error pulses once after the letter gap. Then a dot and 12 low -> E (100) decoded normally.
- 1-cycle high glitches inside the spaces of B, and a lone 1-cycle glitch followed by a gap -> B decoded (001); the lone glitch produces no strobe. A space of 11 cycles between dot and dash -> one letter, A. A space of 12 cycles -> E, then T, and T reports Error.
- ResetN pulled low mid-dash of H, then released -> no strobe, Busy=0, Letter=000. The next clean dot followed by 12 low decodes E.

Source files
------------

// File: rtl/morse_decoder.sv
// morse_decoder
// Receive side of the lab Morse link. The serial line is synchronised, then
// the lengths of its marks and spaces are measured in clock cycles. Marks are
// classified as glitch, dot or dash and shifted into a small symbol buffer.
// After a letter gap the buffer is decoded to a 3-bit letter code (A..H).
// A decoded letter gives a one-cycle LetterValid strobe. A sequence that
// cannot be decoded gives a one-cycle Error strobe instead.

module morse_decoder #(
    parameter int CLOCK_FREQUENCY = 500
) (
    input  logic       ClockIn,
    input  logic       ResetN,
    input  logic       DotDashIn,
    output logic [2:0] Letter,
    output logic       LetterValid,
    output logic       Error,
    output logic       Busy
);

    // One Morse time unit is half a second of clock cycles. The other
    // thresholds are multiples of it. CLOCK_FREQUENCY is expected to be even
    // and at least 8, so that every threshold below is non-zero and distinct.
    localparam logic [31:0] UNIT       = 32'(CLOCK_FREQUENCY / 2);
    localparam logic [31:0] HALF_UNIT  = 32'(CLOCK_FREQUENCY / 4);
    localparam logic [31:0] DASH_MIN   = 32'(2 * (CLOCK_FREQUENCY / 2));
    localparam logic [31:0] LETTER_GAP = 32'(3 * (CLOCK_FREQUENCY / 2));
    localparam logic [31:0] MARK_MAX   = 32'(5 * (CLOCK_FREQUENCY / 2));

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        SPACE,
        EMIT
    } state_t;

    state_t      state;
    state_t      next_state;

    logic        sync_meta;
    logic        sync_s;

    logic [31:0] mark_count;
    logic [31:0] space_count;
    logic [3:0]  sym_buf;
    logic [2:0]  sym_count;
    logic        err_flag;
    logic [2:0]  letter_reg;

    logic [2:0]  dec_code;
    logic        dec_ok;
    logic        emit_valid;
    logic        emit_error;

    logic        mark_done;
    logic        is_glitch;
    logic        is_dash;
    logic        keep_symbol;
    logic        gap_done;

    // The ends of marks and spaces are judged only on the synchronised line
    // and on the current counter values.
    assign mark_done   = (state == MARK) && !sync_s;
    assign is_glitch   = (mark_count < HALF_UNIT);
    assign is_dash     = (mark_count >= DASH_MIN);
    assign keep_symbol = mark_done && !is_glitch;
    assign gap_done    = (space_count >= LETTER_GAP);

    // Two-flop synchroniser. The raw line is asynchronous to ClockIn.
    always_ff @(posedge ClockIn or negedge ResetN) begin
        if (!ResetN) begin
            sync_meta <= 1'b0;
            sync_s    <= 1'b0;
        end else begin
            sync_meta <= DotDashIn;
            sync_s    <= sync_meta;
        end
    end

    // State register.
    always_ff @(posedge ClockIn or negedge ResetN) begin
        if (!ResetN) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A full letter gap wins over a mark that starts in the
    // same cycle. That mark is picked up again from IDLE after EMIT.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (sync_s) begin
                    next_state = MARK;
                end
            end
            MARK: begin
                if (!sync_s) begin
                    next_state = SPACE;
                end
            end
            SPACE: begin
                if (gap_done) begin
                    next_state = EMIT;
                end else if (sync_s) begin
                    next_state = MARK;
                end
            end
            EMIT: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Mark length counter. It restarts at 1 on each new mark and saturates
    // at the over-long limit.
    always_ff @(posedge ClockIn or negedge ResetN) begin
        if (!ResetN) begin
            mark_count <= 32'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (sync_s) begin
                        mark_count <= 32'd1;
                    end
                end
                MARK: begin
                    if (sync_s && (mark_count < MARK_MAX)) begin
                        mark_count <= mark_count + 32'd1;
                    end
                end
                SPACE: begin
                    if (sync_s && !gap_done) begin
                        mark_count <= 32'd1;
                    end
                end
                EMIT: begin
                    mark_count <= 32'd0;
                end
                default: begin
                    mark_count <= 32'd0;
                end
            endcase
        end
    end

    // Space length counter. A glitch leaves it untouched, so the gap keeps
    // counting as if the glitch had never happened.
    always_ff @(posedge ClockIn or negedge ResetN) begin
        if (!ResetN) begin
            space_count <= 32'd0;
        end else begin
            if (state == EMIT) begin
                space_count <= 32'd0;
            end else if (keep_symbol) begin
                space_count <= 32'd1;
            end else if ((state == SPACE) && !sync_s && !gap_done) begin
                space_count <= space_count + 32'd1;
            end
        end
    end

    // Symbol buffer. Dots shift in as 0 and dashes as 1. Once four symbols
    // are held, further symbols are refused and only raise the error flag.
    always_ff @(posedge ClockIn or negedge ResetN) begin
        if (!ResetN) begin
            sym_buf   <= 4'd0;
            sym_count <= 3'd0;
        end else begin
            if (state == EMIT) begin
                sym_buf   <= 4'd0;
                sym_count <= 3'd0;
            end else if (keep_symbol && (sym_count < 3'd4)) begin
                sym_buf   <= {sym_buf[2:0], is_dash};
                sym_count <= sym_count + 3'd1;
            end
        end
    end

    // Sticky error flag for the current letter. It is set by an over-long
    // mark or by a fifth symbol, and cleared once the letter is emitted.
    always_ff @(posedge ClockIn or negedge ResetN) begin
        if (!ResetN) begin
            err_flag <= 1'b0;
        end else begin
            if (state == EMIT) begin
                err_flag <= 1'b0;
            end else if ((state == MARK) && sync_s && (mark_count == MARK_MAX - 32'd1)) begin
                err_flag <= 1'b1;
            end else if (keep_symbol && (sym_count == 3'd4)) begin
                err_flag <= 1'b1;
            end
        end
    end

    // Holds the last decoded letter between strobes.
    always_ff @(posedge ClockIn or negedge ResetN) begin
        if (!ResetN) begin
            letter_reg <= 3'd0;
        end else begin
            if (emit_valid) begin
                letter_reg <= dec_code;
            end
        end
    end

    // Letter table. The first symbol received is the most significant of the
    // used bits. Unused upper bits are always zero because the buffer is
    // cleared between letters.
    always_comb begin
        dec_code = 3'd0;
        dec_ok   = 1'b1;
        unique case ({sym_count, sym_buf})
            {3'd2, 4'b0001}: dec_code = 3'd0;
            {3'd4, 4'b1000}: dec_code = 3'd1;
            {3'd4, 4'b1010}: dec_code = 3'd2;
            {3'd3, 4'b0100}: dec_code = 3'd3;
            {3'd1, 4'b0000}: dec_code = 3'd4;
            {3'd4, 4'b0010}: dec_code = 3'd5;
            {3'd3, 4'b0110}: dec_code = 3'd6;
            {3'd4, 4'b0000}: dec_code = 3'd7;
            default: begin
                dec_code = 3'd0;
                dec_ok   = 1'b0;
            end
        endcase
    end

    // Output logic. Strobes appear only in EMIT. An empty buffer (only
    // glitches seen) stays silent. During the valid strobe the freshly
    // decoded code is shown directly, so Letter is correct in that cycle.
    always_comb begin
        emit_valid = 1'b0;
        emit_error = 1'b0;
        if (state == EMIT) begin
            if (err_flag) begin
                emit_error = 1'b1;
            end else if (sym_count != 3'd0) begin
                if (dec_ok) begin
                    emit_valid = 1'b1;
                end else begin
                    emit_error = 1'b1;
                end
            end
        end
        LetterValid = emit_valid;
        Error       = emit_error;
        Busy        = (state != IDLE);
        Letter      = emit_valid ? dec_code : letter_reg;
    end

endmodule

// File: tb/tb_morse_decoder.sv
// tb_morse_decoder
// Directed bench for morse_decoder at CLOCK_FREQUENCY=8 (UNIT=4). Expected
// strobes are queued as each letter is driven. A negedge monitor pops an entry
// and compares it whenever LetterValid or Error fires.

module tb_morse_decoder;

    localparam int CF = 8;

    logic       ClockIn = 1'b0;
    logic       ResetN;
    logic       DotDashIn;
    logic [2:0] Letter;
    logic       LetterValid;
    logic       Error;
    logic       Busy;

    typedef struct {
        bit         is_err;
        logic [2:0] letter;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         strobe_cyc = -1;
    int         low_start = 0;
    bit         prev_strobe = 1'b0;
    logic [2:0] model_letter = 3'd0;

    logic [4:0] tbl_bits[8] = '{5'b00001, 5'b01000, 5'b01010, 5'b00100,
                                5'b00000, 5'b00010, 5'b00110, 5'b00000};
    int         tbl_len[8]  = '{2, 4, 4, 3, 1, 4, 3, 4};

    morse_decoder #(.CLOCK_FREQUENCY(CF)) dut (
        .ClockIn    (ClockIn),
        .ResetN     (ResetN),
        .DotDashIn  (DotDashIn),
        .Letter     (Letter),
        .LetterValid(LetterValid),
        .Error      (Error),
        .Busy       (Busy)
    );

    // Free-running clock
    always #5 ClockIn = ~ClockIn;

    // Cycle counter used for latency checks
    always @(posedge ClockIn) cyc++;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Monitor: every strobe must match the oldest queued expectation
    always @(negedge ClockIn) begin
        if (ResetN === 1'b1 && (LetterValid === 1'b1 || Error === 1'b1)) begin
            strobe_cyc = cyc;
            check_output("single_cycle_strobe", {31'd0, prev_strobe}, 32'd0);
            check_output("strobe_expected", {31'd0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check_output("letter_valid", {31'd0, LetterValid}, {31'd0, !mon_e.is_err});
                check_output("error", {31'd0, Error}, {31'd0, mon_e.is_err});
                check_output("letter", {29'd0, Letter}, {29'd0, mon_e.letter});
            end
            prev_strobe = 1'b1;
        end else begin
            prev_strobe = 1'b0;
        end
    end

    task automatic apply_stimulus(input logic level, input int cycles);
        repeat (cycles) begin
            @(negedge ClockIn);
            DotDashIn = level;
        end
    endtask

    task automatic push_valid(input logic [2:0] code);
        exp_q.push_back('{is_err: 1'b0, letter: code});
        model_letter = code;
    endtask

    task automatic push_error();
        exp_q.push_back('{is_err: 1'b1, letter: model_letter});
    endtask

    task automatic send_symbols(input logic [4:0] bits, input int n, input int space);
        for (int i = n - 1; i >= 0; i--) begin
            apply_stimulus(1'b1, bits[i] ? 12 : 4);
            if (i > 0) apply_stimulus(1'b0, space);
        end
    endtask

    task automatic wait_drain(input string tag);
        int budget = 40;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge ClockIn);
            budget--;
        end
        check_output({tag, "_drained"}, exp_q.size(), 32'd0);
        check_output({tag, "_busy"}, {31'd0, Busy}, 32'd0);
    endtask

    task automatic end_letter(input string tag);
        apply_stimulus(1'b0, 18);
        wait_drain(tag);
    endtask

    // Watchdog so that a stuck run still ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence
    initial begin
        DotDashIn = 1'b0;
        ResetN    = 1'b0;
        repeat (3) @(negedge ClockIn);
        check_output("reset_letter", {29'd0, Letter}, 32'd0);
        check_output("reset_valid", {31'd0, LetterValid}, 32'd0);
        check_output("reset_error", {31'd0, Error}, 32'd0);
        check_output("reset_busy", {31'd0, Busy}, 32'd0);
        @(negedge ClockIn);
        ResetN = 1'b1;
        apply_stimulus(1'b0, 3);

        // A, with exact strobe latency: 2 sync cycles + 12 gap cycles
        push_valid(3'd0);
        apply_stimulus(1'b1, 4);
        apply_stimulus(1'b0, 4);
        apply_stimulus(1'b1, 12);
        apply_stimulus(1'b0, 1);
        low_start = cyc;
        apply_stimulus(1'b0, 17);
        wait_drain("A");
        check_output("A_latency", strobe_cyc, low_start + 15);

        // C on its own, then the whole table in order
        push_valid(3'd2);
        send_symbols(5'b01010, 4, 4);
        end_letter("C");
        for (int i = 0; i < 8; i++) begin
            push_valid(3'(i));
            send_symbols(tbl_bits[i], tbl_len[i], 4);
            end_letter($sformatf("table%0d", i));
        end

        // O is not in the table; five dots overflow the buffer
        push_error();
        send_symbols(5'b00111, 3, 4);
        end_letter("O_error");
        push_error();
        send_symbols(5'b00000, 5, 4);
        end_letter("five_dots");

        // Over-long mark, then a normal E
        push_error();
        apply_stimulus(1'b1, 24);
        end_letter("long_mark");
        push_valid(3'd4);
        send_symbols(5'b00000, 1, 4);
        end_letter("E_after_long");

        // B with a 1-cycle glitch inside each inter-symbol space
        push_valid(3'd1);
        apply_stimulus(1'b1, 12);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 1);
            apply_stimulus(1'b1, 1);
            apply_stimulus(1'b0, 2);
            apply_stimulus(1'b1, 4);
        end
        end_letter("B_glitch");

        // Lone glitch: no strobe, letter held
        apply_stimulus(1'b1, 1);
        end_letter("lone_glitch");
        check_output("lone_glitch_letter", {29'd0, Letter}, {29'd0, model_letter});

        // Space of 11 keeps the letter together
        push_valid(3'd0);
        apply_stimulus(1'b1, 4);
        apply_stimulus(1'b0, 11);
        apply_stimulus(1'b1, 12);
        end_letter("space11");

        // Space of 12 splits it: E, then T which is undecodable
        push_valid(3'd4);
        push_error();
        apply_stimulus(1'b1, 4);
        apply_stimulus(1'b0, 12);
        apply_stimulus(1'b1, 12);
        end_letter("space12");

        // Reset part-way through H
        apply_stimulus(1'b1, 4);
        apply_stimulus(1'b0, 4);
        apply_stimulus(1'b1, 2);
        @(negedge ClockIn);
        DotDashIn = 1'b0;
        ResetN    = 1'b0;
        model_letter = 3'd0;
        repeat (2) @(negedge ClockIn);
        check_output("midreset_busy", {31'd0, Busy}, 32'd0);
        @(negedge ClockIn);
        ResetN = 1'b1;
        apply_stimulus(1'b0, 20);
        check_output("after_reset_busy", {31'd0, Busy}, 32'd0);
        check_output("after_reset_letter", {29'd0, Letter}, 32'd0);
        push_valid(3'd4);
        send_symbols(5'b00000, 1, 4);
        end_letter("E_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
